// File: rtl/sr_ff_response_checker.sv
// sr_ff_response_checker
//   Watches the S/R/dut_rst commands applied to an SR flip-flop and the Q/Qbar it
//   returns. A cycle-accurate reference model predicts Q. Each valid model update
//   arms one compare that is performed on the following edge. The checker counts
//   the compares performed and the compares that failed.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   sample_en         the flip-flop captures S/R/dut_rst at this edge
//   S, R, dut_rst     commands as applied to the flip-flop (dut_rst dominates)
//   Q, Qbar           flip-flop outputs
//   clear             zeroes counters/flags, keeps the model state
//   exp_q, exp_valid  model prediction and its validity
//   mismatch          one-cycle pulse after a failed compare
//   invalid_seen      sticky: S=R=1 was sampled while synchronised
//   chk_count         saturating count of compares
//   err_count         saturating count of failed compares
//   halted            checker is frozen after MAX_ERR errors
//   state_dbg         current FSM state (UNSYNC=0, TRACK=1, INVALID=2, HALT=3)
//
// Handshake: there is no backpressure. sample_en marks an edge at which the
// flip-flop captures its inputs. The registered Q from that capture is expected
// during the following cycle.
module sr_ff_response_checker #(
  parameter int CNT_W       = 16,
  parameter int MAX_ERR     = 15,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             S,
  input  logic             R,
  input  logic             dut_rst,
  input  logic             Q,
  input  logic             Qbar,
  input  logic             clear,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             invalid_seen,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             halted,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {UNSYNC = 2'd0, TRACK = 2'd1, INVALID = 2'd2, HALT = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic             model_q, model_q_n;
  logic             pend, pend_n;     // compare armed for the next edge
  logic             pend_exp;         // expected Q for that compare
  logic             inv_set;
  logic             cmp_do, cmp_fail, halt_hit;
  logic [CNT_W-1:0] chk_inc, err_inc;

  // A pending compare is discarded by clear and ignored while halted.
  assign cmp_do   = pend && !clear && (state != HALT);
  assign cmp_fail = (Q != pend_exp) || (Qbar == Q);
  assign chk_inc  = (chk_count == CNT_MAX) ? chk_count : chk_count + CNT_W'(1);
  assign err_inc  = (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);
  assign halt_hit = STOP_ON_ERR && cmp_do && cmp_fail && (err_inc == CNT_W'(MAX_ERR));

  always_comb begin
    state_n   = state;
    model_q_n = model_q;
    pend_n    = 1'b0;
    inv_set   = 1'b0;
    if (sample_en && state != HALT) begin
      unique case (state)
        UNSYNC: begin
          if (dut_rst) begin
            state_n   = TRACK;
            model_q_n = 1'b0;
            pend_n    = 1'b1;
          end
        end
        TRACK: begin
          if (dut_rst) begin
            model_q_n = 1'b0;
            pend_n    = 1'b1;
          end else begin
            unique case ({S, R})
              2'b00: pend_n = 1'b1;
              2'b10: begin model_q_n = 1'b1; pend_n = 1'b1; end
              2'b01: begin model_q_n = 1'b0; pend_n = 1'b1; end
              default: begin state_n = INVALID; inv_set = 1'b1; end
            endcase
          end
        end
        INVALID: begin
          if (dut_rst) begin
            state_n = TRACK; model_q_n = 1'b0; pend_n = 1'b1;
          end else if (S && !R) begin
            state_n = TRACK; model_q_n = 1'b1; pend_n = 1'b1;
          end else if (!S && R) begin
            state_n = TRACK; model_q_n = 1'b0; pend_n = 1'b1;
          end else if (S && R) begin
            inv_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // The error that reaches MAX_ERR freezes everything, including the compare
    // that this edge would otherwise arm.
    if (halt_hit) begin
      state_n = HALT;
      pend_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= UNSYNC;
      model_q      <= 1'b0;
      pend         <= 1'b0;
      pend_exp     <= 1'b0;
      mismatch     <= 1'b0;
      invalid_seen <= 1'b0;
      chk_count    <= '0;
      err_count    <= '0;
    end else begin
      state    <= state_n;
      model_q  <= model_q_n;
      pend     <= pend_n;
      pend_exp <= model_q_n;
      if (state == HALT) begin
        mismatch <= 1'b0;
      end else if (clear) begin
        mismatch     <= 1'b0;
        invalid_seen <= 1'b0;
        chk_count    <= '0;
        err_count    <= '0;
      end else begin
        mismatch <= cmp_do && cmp_fail;
        if (cmp_do) chk_count <= chk_inc;
        if (cmp_do && cmp_fail) err_count <= err_inc;
        if (inv_set) invalid_seen <= 1'b1;
      end
    end
  end

  assign exp_q     = model_q;
  assign exp_valid = (state == TRACK) || (state == HALT);
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule
